lcd_arbiter: RTL

- Shares one lcd_controller instance among N_REQ independent character/command sources, such as a boot message sequencer, a core debug port and a status display.
- Grants requests round-robin and drives the controller's iDATA/iRS/iStart/oDone handshake.
- Enforces a post-command settle delay, with a longer delay for clear/home commands.
- Provides per-requester lock, so a multi-character sequence (e.g. a full line) is written atomically.

---
 rtl/lcd_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lcd_arbiter.sv
// Round-robin arbiter sharing one lcd_controller among N_REQ sources, with
// post-write settle delay (longer for clear/home) and per-requester bus lock.
module lcd_arbiter #(
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned DLY_CYCLES     = 2000,
   parameter int unsigned CLR_DLY_CYCLES = 82000
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic [N_REQ-1:0]   iREQ,
   input  logic [9*N_REQ-1:0] iREQ_DATA,
   input  logic [N_REQ-1:0]   iLOCK,
   output logic [N_REQ-1:0]   oACK,
   output logic [2:0]         oOWNER,
   output logic               oBUSY,
   output logic [7:0]         oLCD_DATA,
   output logic               oLCD_RS,
   output logic               oLCD_START,
   input  logic               iLCD_DONE
);

   localparam int unsigned MAX_DLY = (DLY_CYCLES > CLR_DLY_CYCLES) ? DLY_CYCLES : CLR_DLY_CYCLES;
   localparam int unsigned CW      = (MAX_DLY < 1) ? 1 : $clog2(MAX_DLY + 1);
   localparam logic [CW-1:0] DLY_L = CW'(DLY_CYCLES);
   localparam logic [CW-1:0] CLR_L = CW'(CLR_DLY_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT_DONE, SETTLE, ACK} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            hold;
   logic [2:0]      rr_ptr;
   logic [7:0]      req_ext;
   logic [7:0]      lock_ext;
   logic            found;
   logic [2:0]      win;
   logic [2:0]      idx;
   logic            locked;
   logic            gnt_valid;
   logic [2:0]      gnt_idx;
   logic [8:0]      word;
   logic [N_REQ-1:0] ack_vec;
   logic            is_clr;

   assign req_ext  = 8'(iREQ);
   assign lock_ext = 8'(iLOCK);
   assign is_clr   = !oLCD_RS && (oLCD_DATA[7:2] == 6'd0);

   // rr_ptr is the first index searched, so reset gives requester 0 top priority
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = 3'((32'(rr_ptr) + k) % N_REQ);
         if (!found && req_ext[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      locked    = hold && lock_ext[oOWNER];
      gnt_valid = locked ? req_ext[oOWNER] : found;
      gnt_idx   = locked ? oOWNER : win;
      word      = '0;
      ack_vec   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt_idx == 3'(i)) word = iREQ_DATA[9*i +: 9];
         ack_vec[i] = (oOWNER == 3'(i));
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state      <= IDLE;
         cnt        <= '0;
         hold       <= 1'b0;
         rr_ptr     <= '0;
         oACK       <= '0;
         oOWNER     <= '0;
         oBUSY      <= 1'b0;
         oLCD_DATA  <= '0;
         oLCD_RS    <= 1'b0;
         oLCD_START <= 1'b0;
      end else begin
         oACK <= '0;
         case (state)
            IDLE: begin
               // lock released in IDLE: clear hold and arbitrate on this same edge
               if (!locked) hold <= 1'b0;
               if (gnt_valid) begin
                  oOWNER     <= gnt_idx;
                  oLCD_RS    <= word[8];
                  oLCD_DATA  <= word[7:0];
                  oLCD_START <= 1'b1;
                  oBUSY      <= 1'b1;
                  rr_ptr     <= 3'((32'(gnt_idx) + 1) % N_REQ);
                  state      <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (iLCD_DONE) begin
                  oLCD_START <= 1'b0;
                  cnt        <= is_clr ? CLR_L : DLY_L;
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt <= CW'(1)) begin
                  cnt   <= '0;
                  oACK  <= ack_vec;
                  state <= ACK;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ACK: begin
               hold  <= lock_ext[oOWNER];
               oBUSY <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
